// File: rtl/cipher_arb_pkg.sv
// Shared types for the core/DMA memory-port arbiter.
package cipher_arb_pkg;

    typedef enum logic {SRC_CORE, SRC_DMA} arb_src_e;
    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/bus_if.sv
// Simple req/gnt/rvalid memory bus: the master drives the request, the slave answers.
interface bus_if;
    import cipher_arb_pkg::*;

    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/arb_order_fifo.sv
// In-order tracking FIFO holding the source of every granted, unanswered transaction.
module arb_order_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter type         elem_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  elem_t data_i,
    input  logic  pop_i,
    output elem_t head_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    elem_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cipher_bus_arbiter.sv
// Two-to-one arbiter (Ibex data port, cipher DMA) onto one memory port with in-order response routing.
// Define CIPHER_ARB_FIXED_PRIO_EN for fixed core priority; otherwise ties are round-robin.
module cipher_bus_arbiter
    import cipher_arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    bus_if.slave  core_bus,
    bus_if.slave  dma_bus,
    bus_if.master mem_bus,
    output logic  busy_o,
    output logic  unexp_rsp_o
);
    arb_state_e state_q, state_d;
    arb_src_e   hold_src_q, hold_src_d;
    arb_src_e   sel_src;
    arb_src_e   tie_winner;
    arb_src_e   head_src;
    logic       sel_req;
    logic       grant;
    logic       rsp_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       unexp_rsp_q, unexp_rsp_d;

`ifdef CIPHER_ARB_FIXED_PRIO_EN
    assign tie_winner = SRC_CORE;
`else
    arb_src_e last_src_q, last_src_d;

    assign tie_winner = (last_src_q == SRC_CORE) ? SRC_DMA : SRC_CORE;
    assign last_src_d = grant ? sel_src : last_src_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_src_q <= SRC_DMA;
        else         last_src_q <= last_src_d;
    end
`endif

    // While holding, the latched source keeps the address stable until the grant.
    always_comb begin
        sel_src = SRC_CORE;
        if (state_q == ARB_HOLD)               sel_src = hold_src_q;
        else if (core_bus.req && dma_bus.req)  sel_src = tie_winner;
        else if (dma_bus.req)                  sel_src = SRC_DMA;
    end

    assign sel_req       = (sel_src == SRC_CORE) ? core_bus.req : dma_bus.req;
    assign mem_bus.req   = sel_req && !fifo_full;
    assign mem_bus.addr  = (sel_src == SRC_CORE) ? core_bus.addr  : dma_bus.addr;
    assign mem_bus.we    = (sel_src == SRC_CORE) ? core_bus.we    : dma_bus.we;
    assign mem_bus.be    = (sel_src == SRC_CORE) ? core_bus.be    : dma_bus.be;
    assign mem_bus.wdata = (sel_src == SRC_CORE) ? core_bus.wdata : dma_bus.wdata;

    assign grant        = mem_bus.req && mem_bus.gnt;
    assign core_bus.gnt = grant && (sel_src == SRC_CORE);
    assign dma_bus.gnt  = grant && (sel_src == SRC_DMA);

    assign rsp_pop         = mem_bus.rvalid && !fifo_empty;
    assign core_bus.rvalid = rsp_pop && (head_src == SRC_CORE);
    assign dma_bus.rvalid  = rsp_pop && (head_src == SRC_DMA);
    assign core_bus.err    = core_bus.rvalid && mem_bus.err;
    assign dma_bus.err     = dma_bus.rvalid && mem_bus.err;
    assign core_bus.rdata  = mem_bus.rdata;
    assign dma_bus.rdata   = mem_bus.rdata;

    always_comb begin
        state_d    = state_q;
        hold_src_d = hold_src_q;
        if (state_q == ARB_IDLE) begin
            if (mem_bus.req && !mem_bus.gnt) begin
                state_d    = ARB_HOLD;
                hold_src_d = sel_src;
            end
        end else if (grant) begin
            state_d = ARB_IDLE;
        end
    end

    assign unexp_rsp_d = unexp_rsp_q || (mem_bus.rvalid && fifo_empty);
    assign unexp_rsp_o = unexp_rsp_q;
    assign busy_o      = !fifo_empty || (state_q == ARB_HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            hold_src_q  <= SRC_CORE;
            unexp_rsp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_src_q  <= hold_src_d;
            unexp_rsp_q <= unexp_rsp_d;
        end
    end

    arb_order_fifo #(
        .DEPTH  (OUTSTANDING),
        .elem_t (arb_src_e)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sel_src),
        .pop_i   (rsp_pop),
        .head_o  (head_src),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
